// File: rtl/inj_pkg.sv
// Shared defaults, FSM state encoding and mask helper for the error-injection scheduler.
package inj_pkg;

    localparam int NUM_CH_DEF    = 8;
    localparam int PERIOD_W_DEF  = 32;
    localparam int CNT_W_DEF     = 16;
    localparam int PULSE_CYC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        INJECT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Index of the lowest set bit; 0 for an all-zero mask.
    function automatic int lowest_set_idx(input logic [31:0] mask);
        int idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin helper: next set bit of the mask strictly above ptr, wrapping to the lowest set bit.
module rr_next_ch
    import inj_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int IDX_W  = $clog2(NUM_CH_DEF)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  nxt,
    output logic              wrap
);

    always_comb begin
        nxt  = IDX_W'(lowest_set_idx(32'(mask)));
        wrap = 1'b1;
        // Descending scan so the last hit is the closest set bit above ptr.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(ptr))) begin
                nxt  = IDX_W'(i);
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/inj_scheduler.sv
// Issues one-hot enableInj pulses round-robin over a latched channel mask with a programmable gap and round count.
module inj_scheduler
    import inj_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int PERIOD_W  = PERIOD_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [PERIOD_W-1:0] period,
    input  logic [CNT_W-1:0]    burst_len,
    output logic [NUM_CH-1:0]   enableInj,
    output logic [2:0]          cur_ch,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [CNT_W-1:0]    inj_total
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int PC_W  = $clog2(PULSE_CYC + 1);

    state_t                state, state_d;
    logic [PERIOD_W-1:0]   timer, timer_d, period_q;
    logic [NUM_CH-1:0]     mask_q;
    logic [CNT_W-1:0]      burst_q, round_cnt, round_d, round_inc, total_d;
    logic [PC_W-1:0]       pcnt, pcnt_d;
    logic [IDX_W-1:0]      ptr, ptr_d, nxt_idx;
    logic                  wrap;
    logic                  accept;
    logic                  err_d;
    logic [NUM_CH-1:0]     en_d;
    logic [2:0]            cur_d;

    rr_next_ch #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_next_ch (
        .mask (mask_q),
        .ptr  (ptr),
        .nxt  (nxt_idx),
        .wrap (wrap)
    );

    assign accept    = (state == IDLE) && start && !stop && (ch_mask != '0) && (period != '0);
    assign round_inc = round_cnt + 1'b1;

    always_comb begin
        state_d = state;
        timer_d = timer;
        pcnt_d  = pcnt;
        ptr_d   = ptr;
        round_d = round_cnt;
        total_d = inj_total;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    timer_d = period;
                    ptr_d   = IDX_W'(lowest_set_idx(32'(ch_mask)));
                    round_d = '0;
                    total_d = '0;
                end else if (start && !stop) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (timer == PERIOD_W'(1)) begin
                    state_d = INJECT;
                    pcnt_d  = '0;
                    if (inj_total != '1) total_d = inj_total + 1'b1;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end
            INJECT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (pcnt == PC_W'(PULSE_CYC - 1)) begin
                    ptr_d = nxt_idx;
                    if (wrap) round_d = round_inc;
                    if (wrap && (burst_q != '0) && (round_inc == burst_q)) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        timer_d = period_q;
                    end
                end else begin
                    pcnt_d = pcnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        en_d  = '0;
        cur_d = '0;
        if (state_d == INJECT) en_d = NUM_CH'(1) << ptr_d;
        if ((state_d == WAIT) || (state_d == INJECT)) cur_d = 3'(ptr_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            pcnt      <= '0;
            ptr       <= '0;
            round_cnt <= '0;
            inj_total <= '0;
            enableInj <= '0;
            cur_ch    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            pcnt      <= pcnt_d;
            ptr       <= ptr_d;
            round_cnt <= round_d;
            inj_total <= total_d;
            enableInj <= en_d;
            cur_ch    <= cur_d;
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
            cfg_err   <= err_d;
        end
    end

    // Run configuration is only captured when a start is accepted.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mask_q   <= ch_mask;
            period_q <= period;
            burst_q  <= burst_len;
        end
    end

endmodule

// File: tb/tb_inj_scheduler.sv
// Directed bench for inj_scheduler: pulse timing, channel order, config rejects, stop/reset handling.
module tb_inj_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [7:0]  ch_mask;
    logic [31:0] period;
    logic [15:0] burst_len;
    logic [7:0]  enableInj;
    logic [2:0]  cur_ch;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] inj_total;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ch[16];
    int spur_k = -1;

    inj_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .ch_mask   (ch_mask),
        .period    (period),
        .burst_len (burst_len),
        .enableInj (enableInj),
        .cur_ch    (cur_ch),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .inj_total (inj_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] exp_total);
        chk_val({tag, "_en"},    enableInj, 8'h00);
        chk_val({tag, "_busy"},  busy,      1'b0);
        chk_val({tag, "_done"},  done,      1'b0);
        chk_val({tag, "_err"},   cfg_err,   1'b0);
        chk_val({tag, "_cur"},   cur_ch,    3'd0);
        chk_val({tag, "_total"}, inj_total, exp_total);
    endtask

    // Pulse j rises first+gap*j cycles after the start edge and stays high 4 cycles on exp_ch[j].
    task automatic run_seq(input string tag, input int first, input int gap, input int npulse,
                           input int done_at, input int ncyc);
        logic [7:0] e_en;
        logic [2:0] e_cur;
        logic       e_busy;
        bit         found;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            e_en  = 8'h00;
            e_cur = 3'd0;
            found = 1'b0;
            for (int j = 0; j < npulse; j++) begin
                if (k >= first + gap * j && k < first + gap * j + 4) e_en = 8'(1) << exp_ch[j];
                if (!found && k < first + gap * j + 4) begin
                    e_cur = 3'(exp_ch[j]);
                    found = 1'b1;
                end
            end
            e_busy = (done_at < 0) ? 1'b1 : (k <= done_at);
            chk_val($sformatf("%s_en_k%0d", tag, k),   enableInj, e_en);
            chk_val($sformatf("%s_done_k%0d", tag, k), done,      (k == done_at));
            chk_val($sformatf("%s_busy_k%0d", tag, k), busy,      e_busy);
            chk_val($sformatf("%s_cur_k%0d", tag, k),  cur_ch,    e_cur);
            if (k == spur_k) begin
                start     = 1'b1;
                ch_mask   = 8'h80;
                period    = 32'd1;
                burst_len = 16'd1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic kick(input logic [7:0] m, input logic [31:0] p, input logic [15:0] b);
        ch_mask   = m;
        period    = p;
        burst_len = b;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        ch_mask = 8'h00; period = 32'd0; burst_len = 16'd0;
        tick();
        tick();
        chk_idle("reset", 16'd0);
        reset = 1'b0;
        tick();
        chk_idle("post_reset", 16'd0);

        // Three-channel mask, two rounds: ch0,3,7,0,3,7 every 14 cycles from T+10.
        exp_ch[0] = 0; exp_ch[1] = 3; exp_ch[2] = 7;
        exp_ch[3] = 0; exp_ch[4] = 3; exp_ch[5] = 7;
        kick(8'b1000_1001, 32'd10, 16'd2);
        run_seq("burst", 10, 14, 6, 84, 86);
        chk_val("burst_total", inj_total, 16'd6);

        // Rejected starts.
        kick(8'h00, 32'd5, 16'd1);
        chk_val("mask0_err",  cfg_err,   1'b1);
        chk_val("mask0_busy", busy,      1'b0);
        chk_val("mask0_en",   enableInj, 8'h00);
        tick();
        chk_idle("mask0_after", 16'd6);
        kick(8'h01, 32'd0, 16'd1);
        chk_val("per0_err",  cfg_err,   1'b1);
        chk_val("per0_busy", busy,      1'b0);
        tick();
        chk_idle("per0_after", 16'd6);

        // Single channel, endless: every pulse is a round, spacing 7.
        for (int j = 0; j < 16; j++) exp_ch[j] = 4;
        kick(8'h10, 32'd3, 16'd0);
        run_seq("single", 3, 7, 15, -1, 100);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle("single_stop", 16'd14);
        tick();
        chk_idle("single_stop2", 16'd14);

        // Stop sampled in the 2nd INJECT cycle truncates the pulse but keeps it counted.
        exp_ch[0] = 1;
        kick(8'h02, 32'd2, 16'd0);
        run_seq("trunc", 2, 6, 1, -1, 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle("trunc_stop", 16'd1);

        // Start and stop together in IDLE, with a mask that would otherwise raise cfg_err.
        ch_mask = 8'h00; period = 32'd4;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk_idle("startstop", 16'd1);

        // Start while busy with a different config is ignored.
        exp_ch[0] = 1; exp_ch[1] = 2; exp_ch[2] = 1; exp_ch[3] = 2;
        spur_k = 3;
        kick(8'h06, 32'd2, 16'd2);
        run_seq("busy_start", 2, 6, 4, 24, 25);
        spur_k = -1;
        start = 1'b0;
        chk_val("busy_start_total", inj_total, 16'd4);

        // Reset in the middle of a pulse, then a fresh single-round run.
        kick(8'h01, 32'd2, 16'd1);
        tick();
        tick();
        chk_val("pre_rst_en", enableInj, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("mid_rst", 16'd0);
        exp_ch[0] = 0;
        kick(8'h01, 32'd2, 16'd1);
        run_seq("fresh", 2, 6, 1, 6, 7);
        chk_val("fresh_total", inj_total, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inj_scheduler.md
Name: inj_scheduler

Overview:
Sequences error injection into the PRBS31 data sources across the 8 GTX transmit lanes. The block generates one-hot `enableInj` pulses round-robin over a latched channel mask, with a programmable gap between pulses and a programmable number of rounds. It counts the injections it issues, so software can check them against the per-channel `Rx_injectErrorCount` readback. It sits between the control-register block and the `enableInj[7:0]` input of the data source.

Parameters:
NUM_CH, 8, number of transmit lanes / width of `enableInj`
PERIOD_W, 32, width of the gap timer and `period` input
CNT_W, 16, width of the round and total-injection counters
PULSE_CYC, 4, cycles each `enableInj` pulse is held high (lets slower or equal Tx clocks sample it)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a sequence
stop  in  1  single-cycle abort request
ch_mask  in  NUM_CH  channels to inject; latched when start is accepted
period  in  PERIOD_W  idle cycles between pulses; latched when start is accepted
burst_len  in  CNT_W  rounds to run; 0 = run until stop
enableInj  out  NUM_CH  one-hot injection pulse to the data source
cur_ch  out  3  index of the channel targeted now or next
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when burst_len rounds complete
cfg_err  out  1  one-cycle pulse when start is rejected
inj_total  out  CNT_W  injections issued since the last accepted start; saturating

Behaviour:
- Reset: state=IDLE; all outputs are 0; timers, pointer and counters are cleared. Reset has priority over every other input.
- States: IDLE, WAIT, INJECT, DONE. All outputs are registered.
- IDLE:
  - start=1, stop=0, ch_mask!=0, period!=0: latch mask, period and burst_len; clear inj_total and round_cnt; set ptr to the lowest set bit of the mask; load timer=period; go to WAIT.
  - start=1 with ch_mask==0 or period==0: stay in IDLE and pulse cfg_err for one cycle.
  - start and stop in the same cycle: stop wins; stay in IDLE with no cfg_err.
- WAIT:
  - Timer decrements each cycle.
  - When timer==1, go to INJECT. The enableInj[ptr] rising edge appears exactly `period` cycles after the cycle start was sampled.
- INJECT:
  - enableInj = 1<<ptr for exactly PULSE_CYC cycles.
  - inj_total increments on the first INJECT cycle and saturates at all-ones.
  - On the last cycle, ptr advances to the next set bit of the latched mask above ptr, wrapping to the lowest set bit.
  - On a wrap, round_cnt increments. If burst_len!=0 and the new round_cnt==burst_len, go to DONE. Otherwise reload timer=period and go to WAIT.
  - Start-to-start spacing between pulses is PULSE_CYC+period cycles.
- Single-bit mask: every pulse wraps, so each pulse counts as one round.
- DONE: done=1 for one cycle, then IDLE. inj_total holds its value until the next accepted start.
- stop in WAIT, INJECT or DONE: go to IDLE on the next edge. enableInj is 0 from that edge on, so an in-flight pulse is truncated but stays counted. done is not asserted.
- start while busy: ignored. Changes to ch_mask, period or burst_len while busy are also ignored.
- cur_ch = ptr in WAIT and INJECT; 0 in IDLE.
- round_cnt is CNT_W wide. With burst_len=0, round_cnt may wrap and this has no effect on behaviour.

Decomposition:
- Shared package `inj_pkg` holds:
  - NUM_CH, PERIOD_W, CNT_W and PULSE_CYC defaults;
  - the state enum (IDLE, WAIT, INJECT, DONE);
  - a function returning the lowest set bit index of a mask.
- One sub-module, `rr_next_ch`: combinational next-set-bit finder.
  - Inputs: mask, ptr.
  - Outputs: next index, wrap flag.

Test Plan:
- Sequence: reset, then start with mask=8'b1000_1001, period=10, burst_len=2.
  - Pulses go to ch0,3,7,0,3,7, with rising edges at T+10, T+24, T+38, T+52, T+66, T+80, each 4 cycles wide.
  - done is high at T+84; inj_total=6; busy drops at T+85.
- Start with mask=0 -> cfg_err for 1 cycle; busy stays 0; no enableInj activity.
- Start with period=0 -> cfg_err for 1 cycle; busy stays 0; no enableInj activity.
- mask=8'h10, period=3, burst_len=0 run for 100 cycles, then stop -> only enableInj[4] toggles, with spacing 7; after the stop edge, enableInj=0, busy=0, done never pulses.
- Stop asserted in the 2nd INJECT cycle -> enableInj=0 on the next edge; inj_total already includes that pulse.
- Start and stop together in IDLE -> no state change, no cfg_err.
- Start re-asserted while busy with a different mask -> ignored; the original channel order continues.
- Reset asserted mid-INJECT -> all outputs 0 on the next edge; a following start behaves exactly like a fresh run.
